// File: rtl/deserializer_rx_if.sv
// Serial receive bundle: the rxd line plus the parallel byte, strobes and status it produces.
interface deserializer_rx_if #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
);
  logic                 rxd;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic [CNT_W-1:0]     frame_cnt;
  logic                 busy;

  modport master (
    output rxd,
    input  data, valid, parity_err, frame_err, frame_cnt, busy
  );

  modport slave (
    input  rxd,
    output data, valid, parity_err, frame_err, frame_cnt, busy
  );
endinterface

// File: rtl/deserializer_rx.sv
// Serial-to-parallel receiver: start '1', DATA_BITS data MSB first, one parity bit, STOP_BITS stop '0's.
// Completed frames are presented with a one-cycle valid strobe, held data/error flags and a frame counter.
module deserializer_rx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 2,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  deserializer_rx_if.slave     io
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Wide enough for the largest DATA_BITS (16) and STOP_BITS (4) counts
  localparam logic [4:0] DATA_LAST = 5'(DATA_BITS - 1);
  localparam logic [4:0] STOP_LAST = 5'(STOP_BITS - 1);

  state_t               state_r, state_nx_s;
  logic [DATA_BITS-1:0] shift_r, shift_nx_s;
  logic [4:0]           bit_cnt_r, bit_cnt_nx_s;
  logic                 acc_r, acc_nx_s;
  logic                 par_err_r, par_err_nx_s;
  logic                 stop_err_r, stop_err_nx_s;
  logic                 done_s;

  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 parity_err_r;
  logic                 frame_err_r;
  logic [CNT_W-1:0]     frame_cnt_r;
  logic                 busy_r;

  // Accumulator holds the xor of all data bits; folding in the parity bit must give PARITY_ODD
  function automatic logic parity_err_f(input logic acc, input logic par_bit);
    return acc ^ par_bit ^ (PARITY_ODD != 0);
  endfunction

  // Next-state and datapath update for the frame FSM
  always_comb begin
    state_nx_s    = state_r;
    shift_nx_s    = shift_r;
    bit_cnt_nx_s  = bit_cnt_r;
    acc_nx_s      = acc_r;
    par_err_nx_s  = par_err_r;
    stop_err_nx_s = stop_err_r;
    done_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (io.rxd) begin
          state_nx_s   = ST_DATA;
          bit_cnt_nx_s = 5'd0;
          acc_nx_s     = 1'b0;
        end else begin
          state_nx_s   = ST_IDLE;
        end
      end
      ST_DATA: begin
        shift_nx_s = (shift_r << 1) | DATA_BITS'(io.rxd);
        acc_nx_s   = acc_r ^ io.rxd;
        if (bit_cnt_r == DATA_LAST) begin
          state_nx_s   = ST_PARITY;
          bit_cnt_nx_s = 5'd0;
        end else begin
          bit_cnt_nx_s = bit_cnt_r + 5'd1;
        end
      end
      ST_PARITY: begin
        par_err_nx_s  = parity_err_f(acc_r, io.rxd);
        stop_err_nx_s = 1'b0;
        bit_cnt_nx_s  = 5'd0;
        state_nx_s    = ST_STOP;
      end
      ST_STOP: begin
        if (io.rxd) begin
          stop_err_nx_s = 1'b1;
        end else begin
          stop_err_nx_s = stop_err_r;
        end
        // Frame always runs to full length, even with a bad stop bit
        if (bit_cnt_r == STOP_LAST) begin
          state_nx_s = ST_IDLE;
          done_s     = 1'b1;
        end else begin
          bit_cnt_nx_s = bit_cnt_r + 5'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset wins over a completing frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      shift_r      <= '0;
      bit_cnt_r    <= 5'd0;
      acc_r        <= 1'b0;
      par_err_r    <= 1'b0;
      stop_err_r   <= 1'b0;
      data_r       <= '0;
      valid_r      <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      frame_cnt_r  <= '0;
      busy_r       <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      shift_r    <= shift_nx_s;
      bit_cnt_r  <= bit_cnt_nx_s;
      acc_r      <= acc_nx_s;
      par_err_r  <= par_err_nx_s;
      stop_err_r <= stop_err_nx_s;
      valid_r    <= done_s;
      busy_r     <= (state_nx_s != ST_IDLE);
      if (done_s) begin
        data_r       <= shift_r;
        parity_err_r <= par_err_r;
        frame_err_r  <= stop_err_nx_s;
        frame_cnt_r  <= frame_cnt_r + CNT_W'(1);
      end
    end
  end

  assign io.data       = data_r;
  assign io.valid      = valid_r;
  assign io.parity_err = parity_err_r;
  assign io.frame_err  = frame_err_r;
  assign io.frame_cnt  = frame_cnt_r;
  assign io.busy       = busy_r;

endmodule

// File: tb/tb_deserializer_rx.sv
// Randomized scoreboard bench for deserializer_rx: a driver serializes frames and queues the
// expected result; a monitor pops and compares on every valid strobe.
module tb_deserializer_rx;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   model_cnt;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  deserializer_rx_if #(.DATA_BITS(8), .CNT_W(8)) bus ();

  deserializer_rx #(
    .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid strobe must match the oldest queued frame, including its arrival cycle
  always @(negedge clk) begin
    if (!rst && bus.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data",       {24'd0, bus.data},      {24'd0, e.d});
        chk("parity_err", {31'd0, bus.parity_err}, {31'd0, e.pe});
        chk("frame_err",  {31'd0, bus.frame_err},  {31'd0, e.fe});
        chk("frame_cnt",  {24'd0, bus.frame_cnt},  {24'd0, e.cnt});
        chk("valid_time", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the last stop-bit edge
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic [1:0] stop);
    logic [11:0] bits;
    exp_t        e;
    bits      = {1'b1, d, (^d) ^ bad_par, stop};
    model_cnt = (model_cnt + 1) % 256;
    e.d   = d;
    e.pe  = bad_par;
    e.fe  = |stop;
    e.cnt = 8'(model_cnt);
    e.cyc = cyc + 12;
    exp_q.push_back(e);
    for (int i = 11; i >= 0; i--) begin
      bus.rxd = bits[i];
      @(negedge clk);
      if (i == 11) chk("busy_in_frame", {31'd0, bus.busy}, 32'd1);
    end
    bus.rxd = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rxd = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.rxd = 1'b0;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    model_cnt = 0;
    exp_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data"},  {24'd0, bus.data},       32'd0);
    chk({tag, "_valid"}, {31'd0, bus.valid},      32'd0);
    chk({tag, "_perr"},  {31'd0, bus.parity_err}, 32'd0);
    chk({tag, "_ferr"},  {31'd0, bus.frame_err},  32'd0);
    chk({tag, "_cnt"},   {24'd0, bus.frame_cnt},  32'd0);
    chk({tag, "_busy"},  {31'd0, bus.busy},       32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    checks    = 0;
    errors    = 0;
    model_cnt = 0;
    cyc       = 0;
    rst       = 1'b1;
    bus.rxd   = 1'b0;
    @(negedge clk);
    do_reset();
    chk_outputs_zero("reset");

    // Idle line: nothing happens
    idle(20);
    chk_outputs_zero("idle");

    // Reference frame A5
    send_frame(8'hA5, 1'b0, 2'b00);
    idle(3);
    chk("busy_after_frame", {31'd0, bus.busy}, 32'd0);
    chk("data_held", {24'd0, bus.data}, 32'hA5);

    // 16 back-to-back frames 00..0F
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 2'b00);
    idle(2);

    // Parity error, then a good frame clears it
    send_frame(8'h3C, 1'b1, 2'b00);
    send_frame(8'h01, 1'b0, 2'b00);
    idle(2);

    // Framing error on second stop bit, then idle stays idle
    send_frame(8'h55, 1'b0, 2'b01);
    idle(5);
    chk("busy_idle_after_ferr", {31'd0, bus.busy}, 32'd0);

    // Both errors at once
    send_frame(8'hC3, 1'b1, 2'b10);
    idle(2);
    drain();

    // Reset in the middle of data bit 4
    bus.rxd = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rxd = 1'(i & 1);
      @(negedge clk);
    end
    do_reset();
    chk_outputs_zero("midreset");
    idle(3);
    send_frame(8'hFF, 1'b0, 2'b00);
    idle(2);
    drain();

    // Randomized frames with random gaps and occasional errors
    for (int i = 0; i < 60; i++) begin
      rd = 8'($urandom);
      send_frame(rd, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      idle($urandom_range(0, 3));
    end
    drain();

    // Counter wrap: 256 frames after reset end at frame_cnt 0
    do_reset();
    for (int i = 0; i < 256; i++) send_frame(8'($urandom), 1'b0, 2'b00);
    idle(2);
    drain();
    chk("wrap_cnt", {24'd0, bus.frame_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
